// File: rtl/synth_pkg.sv
// Shared encodings for the synth voice: envelope states, waveform codes and
// the noise LFSR constants and step function.
package synth_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam logic [2:0] WAVE_SAW   = 3'd0;
    localparam logic [2:0] WAVE_PULSE = 3'd1;
    localparam logic [2:0] WAVE_TRI   = 3'd2;
    localparam logic [2:0] WAVE_SUB   = 3'd3;
    localparam logic [2:0] WAVE_NOISE = 3'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/synth_voice_adsr.sv
// ADSR envelope: free-running tick divider, gate edge detect, state machine
// and saturating level datapath.
module adsr_env
    import synth_pkg::*;
#(
    parameter int ENV_W   = 16,
    parameter int ENV_DIV = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic [ENV_W-1:0] attack_rate,
    input  logic [ENV_W-1:0] decay_rate,
    input  logic [ENV_W-1:0] release_rate,
    input  logic [ENV_W-1:0] sustain_level,
    output logic [ENV_W-1:0] level,
    output logic [2:0]       state
);

    localparam int CNT_W = (ENV_DIV > 2) ? $clog2(ENV_DIV) : 1;
    localparam logic [ENV_W-1:0] LEVEL_MAX = '1;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             gate_r;
    logic             gate_q;
    logic             rise;
    env_state_t       state_r;
    logic [ENV_W-1:0] level_r;
    logic [ENV_W:0]   up_sum;
    logic [ENV_W:0]   dn_decay;
    logic [ENV_W:0]   dn_release;

    assign tick       = (tick_cnt == CNT_W'(ENV_DIV - 1));
    // gate is registered once before edge detection, so the FSM reacts two edges after a change.
    assign rise       = gate_r & ~gate_q;
    assign up_sum     = {1'b0, level_r} + {1'b0, attack_rate};
    assign dn_decay   = {1'b0, level_r} - {1'b0, decay_rate};
    assign dn_release = {1'b0, level_r} - {1'b0, release_rate};

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            gate_r   <= 1'b0;
            gate_q   <= 1'b0;
            level_r  <= '0;
            state_r  <= ENV_IDLE;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            gate_r   <= gate;
            gate_q   <= gate_r;
            if (rise) begin
                state_r <= ENV_ATTACK;
            end else if (!gate_r && (state_r == ENV_ATTACK || state_r == ENV_DECAY ||
                                     state_r == ENV_SUSTAIN)) begin
                state_r <= ENV_RELEASE;
            end else if (tick) begin
                case (state_r)
                    ENV_ATTACK: begin
                        if (attack_rate != '0) begin
                            if (up_sum >= {1'b0, LEVEL_MAX}) begin
                                level_r <= LEVEL_MAX;
                                state_r <= ENV_DECAY;
                            end else begin
                                level_r <= up_sum[ENV_W-1:0];
                            end
                        end
                    end
                    ENV_DECAY: begin
                        // A zero rate stalls unless the level already sits at or below sustain.
                        if (decay_rate != '0 || level_r <= sustain_level) begin
                            if (dn_decay[ENV_W] || dn_decay[ENV_W-1:0] <= sustain_level) begin
                                level_r <= sustain_level;
                                state_r <= ENV_SUSTAIN;
                            end else begin
                                level_r <= dn_decay[ENV_W-1:0];
                            end
                        end
                    end
                    ENV_SUSTAIN: level_r <= sustain_level;
                    ENV_RELEASE: begin
                        if (release_rate != '0) begin
                            if (dn_release[ENV_W] || dn_release[ENV_W-1:0] == '0) begin
                                level_r <= '0;
                                state_r <= ENV_IDLE;
                            end else begin
                                level_r <= dn_release[ENV_W-1:0];
                            end
                        end
                    end
                    default: level_r <= '0;
                endcase
            end
        end
    end

    assign level = level_r;
    assign state = state_r;

endmodule

// File: rtl/synth_voice.sv
// One synthesiser voice: phase accumulator, waveform select, noise LFSR and
// envelope multiply producing one unsigned sample per clock.
module synth_voice
    import synth_pkg::*;
#(
    parameter int PHASE_W = 29,
    parameter int INC_W   = 18,
    parameter int OUT_W   = 16,
    parameter int ENV_W   = 16,
    parameter int ENV_DIV = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] increment,
    input  logic [2:0]       wave_sel,
    input  logic [OUT_W-1:0] pulsewidth,
    input  logic             gate,
    input  logic [ENV_W-1:0] attack_rate,
    input  logic [ENV_W-1:0] decay_rate,
    input  logic [ENV_W-1:0] release_rate,
    input  logic [ENV_W-1:0] sustain_level,
    output logic [OUT_W-1:0] sample,
    output logic [ENV_W-1:0] env_level,
    output logic [2:0]       env_state,
    output logic             busy
);

    localparam int PROD_W = OUT_W + ENV_W;

    logic [PHASE_W-1:0] acc;
    logic [15:0]        lfsr;
    logic               half_q;
    logic [OUT_W-1:0]   phase;
    logic [OUT_W-1:0]   tri_raw;
    logic [OUT_W-1:0]   wave;
    logic [ENV_W-1:0]   level;
    logic [2:0]         state;
    logic [PROD_W-1:0]  product;

    adsr_env #(
        .ENV_W   (ENV_W),
        .ENV_DIV (ENV_DIV)
    ) u_env (
        .clk           (clk),
        .rst           (rst),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .release_rate  (release_rate),
        .sustain_level (sustain_level),
        .level         (level),
        .state         (state)
    );

    assign phase   = acc[PHASE_W-2 -: OUT_W];
    assign tri_raw = acc[PHASE_W-3 -: OUT_W];

    always_comb begin
        wave = '0;
        case (wave_sel)
            WAVE_SAW:   wave = phase;
            WAVE_PULSE: wave = (phase < pulsewidth) ? '1 : '0;
            WAVE_TRI:   wave = acc[PHASE_W-2] ? ~tri_raw : tri_raw;
            WAVE_SUB:   wave = {OUT_W{acc[PHASE_W-1]}};
            WAVE_NOISE: wave = OUT_W'(lfsr);
            default:    wave = '0;
        endcase
    end

    assign product = PROD_W'(wave) * PROD_W'(level);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            lfsr   <= LFSR_SEED;
            half_q <= 1'b0;
            sample <= '0;
        end else begin
            acc    <= acc + PHASE_W'(increment);
            half_q <= acc[PHASE_W-2];
            // Noise steps once per half-phase rise so its pitch follows increment.
            if (acc[PHASE_W-2] && !half_q) begin
                lfsr <= lfsr_step(lfsr);
            end
            sample <= product[PROD_W-1 -: OUT_W];
        end
    end

    assign env_level = level;
    assign env_state = state;
    assign busy      = (state != ENV_IDLE);

endmodule
